// File: rtl/filter_addr_sequencer.sv
// rtl/filter_addr_sequencer.sv - filter bank element read-address sequencer
module filter_addr_sequencer #(
    parameter int ADDR_WIDTH        = 16,
    parameter int FILTER_SIZE_WIDTH = 4,
    parameter int FILTER_CNT_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_WIDTH-1:0]       base_addr,
    input  logic [FILTER_SIZE_WIDTH-1:0] filter_size,
    input  logic [FILTER_CNT_WIDTH-1:0] num_filters,
    input  logic                        interleaved_mode,
    input  logic                        next_filter,
    input  logic                        addr_ready,
    output logic                        addr_valid,
    output logic [ADDR_WIDTH-1:0]       addr,
    output logic                        last_elem,
    output logic [ADDR_WIDTH-1:0]       filter_start_addr,
    output logic [FILTER_CNT_WIDTH-1:0] filter_idx,
    output logic                        busy,
    output logic                        done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [FILTER_SIZE_WIDTH-1:0] SIZE_ONE = 1;
    localparam logic [FILTER_CNT_WIDTH-1:0]  CNT_ONE  = 1;

    logic [1:0]                   state_q, state_d;
    logic [FILTER_SIZE_WIDTH-1:0] size_q, size_d;
    logic [FILTER_CNT_WIDTH-1:0]  num_q, num_d;
    logic                         inter_q, inter_d;
    logic [ADDR_WIDTH-1:0]        fs_q, fs_d;
    logic [ADDR_WIDTH-1:0]        fstart_q, fstart_d;
    logic [FILTER_CNT_WIDTH-1:0]  idx_q, idx_d;
    logic [FILTER_SIZE_WIDTH-1:0] e_q, e_d;

    logic [ADDR_WIDTH-1:0] size_ext;
    logic [ADDR_WIDTH-1:0] fs_new;
    logic [ADDR_WIDTH-1:0] e_ext;
    logic [ADDR_WIDTH-1:0] e_off;
    logic                  is_last;
    logic                  advance;

    // Filter stride is fixed at start so later input changes cannot disturb the pass.
    assign size_ext = ADDR_WIDTH'(filter_size);
    assign fs_new   = interleaved_mode ? (size_ext << 1) : size_ext;
    assign e_ext    = ADDR_WIDTH'(e_q);
    assign e_off    = inter_q ? (e_ext << 1) : e_ext;
    assign is_last  = (e_q == (size_q - SIZE_ONE));

    assign addr              = fstart_q + e_off;
    assign addr_valid        = (state_q == ST_RUN);
    assign last_elem         = (state_q == ST_RUN) && is_last;
    assign filter_start_addr = fstart_q;
    assign filter_idx        = idx_q;
    assign busy              = (state_q != ST_IDLE);
    assign done              = (state_q == ST_DONE);

    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        num_d    = num_q;
        inter_d  = inter_q;
        fs_d     = fs_q;
        fstart_d = fstart_q;
        idx_d    = idx_q;
        e_d      = e_q;
        advance  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    size_d   = filter_size;
                    num_d    = num_filters;
                    inter_d  = interleaved_mode;
                    fs_d     = fs_new;
                    fstart_d = base_addr;
                    idx_d    = '0;
                    e_d      = '0;
                    if (filter_size == '0 || num_filters == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // A skip request takes priority over a concurrent handshake.
                if (next_filter) begin
                    advance = 1'b1;
                end else if (addr_ready) begin
                    if (is_last) begin
                        state_d = ST_WAIT;
                    end else begin
                        e_d = e_q + SIZE_ONE;
                    end
                end
            end
            ST_WAIT: begin
                if (next_filter) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (advance) begin
            if (idx_q == (num_q - CNT_ONE)) begin
                state_d = ST_DONE;
            end else begin
                fstart_d = fstart_q + fs_q;
                idx_d    = idx_q + CNT_ONE;
                e_d      = '0;
                state_d  = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            size_q   <= '0;
            num_q    <= '0;
            inter_q  <= 1'b0;
            fs_q     <= '0;
            fstart_q <= '0;
            idx_q    <= '0;
            e_q      <= '0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            num_q    <= num_d;
            inter_q  <= inter_d;
            fs_q     <= fs_d;
            fstart_q <= fstart_d;
            idx_q    <= idx_d;
            e_q      <= e_d;
        end
    end

endmodule

// File: tb/tb_filter_addr_sequencer.sv
// tb/tb_filter_addr_sequencer.sv - self-checking bench for filter_addr_sequencer
module tb_filter_addr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [3:0]  filter_size;
    logic [7:0]  num_filters;
    logic        interleaved_mode;
    logic        next_filter;
    logic        addr_ready;
    logic        addr_valid;
    logic [15:0] addr;
    logic        last_elem;
    logic [15:0] filter_start_addr;
    logic [7:0]  filter_idx;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] addr;
        logic        last;
        logic [7:0]  idx;
        logic [15:0] fst;
    } exp_t;

    typedef struct {
        logic [15:0] base;
        logic [3:0]  size;
        logic [7:0]  num;
        logic        inter;
        logic [15:0] exp_fstart;
        logic [7:0]  exp_idx;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[5];

    filter_addr_sequencer #(
        .ADDR_WIDTH(16), .FILTER_SIZE_WIDTH(4), .FILTER_CNT_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .filter_size(filter_size), .num_filters(num_filters),
        .interleaved_mode(interleaved_mode), .next_filter(next_filter),
        .addr_ready(addr_ready), .addr_valid(addr_valid), .addr(addr),
        .last_elem(last_elem), .filter_start_addr(filter_start_addr),
        .filter_idx(filter_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_elem(input logic [15:0] b, input logic [3:0] s, input logic inter,
                             input int f, input int e);
        exp_t x;
        logic [15:0] es, fs, fst;
        es     = inter ? 16'd2 : 16'd1;
        fs     = 16'(s) * es;
        fst    = b + 16'(f) * fs;
        x.addr = fst + 16'(e) * es;
        x.last = (e == int'(s) - 1);
        x.idx  = 8'(f);
        x.fst  = fst;
        sb.push_back(x);
    endtask

    // Every accepted address is popped from the scoreboard in order.
    always @(negedge clk) begin
        exp_t x;
        #1;
        if (rst && addr_valid && addr_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_handshake actual=%0h required=none", addr);
            end else begin
                x = sb.pop_front();
                chk("handshake{addr,last,idx,fst}", {addr, last_elem, filter_idx, filter_start_addr},
                    {x.addr, x.last, x.idx, x.fst});
            end
        end
    end

    task automatic start_pass(input logic [15:0] b, input logic [3:0] s, input logic [7:0] n,
                              input logic inter);
        @(negedge clk);
        base_addr = b; filter_size = s; num_filters = n; interleaved_mode = inter;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base_addr = 16'($urandom); filter_size = 4'($urandom);
        num_filters = 8'($urandom); interleaved_mode = 1'($urandom);
    endtask

    // Pulses next_filter whenever WAIT is seen, expects done right after the last pulse.
    task automatic finish_pass(input int nf_need);
        int nf;
        bit ok;
        nf = 0;
        ok = 1'b0;
        for (int cyc = 0; cyc < 400 && !ok; cyc++) begin
            @(negedge clk);
            next_filter = 1'b0;
            if (nf == nf_need) begin
                chk("done_after_last_advance", done, 1'b1);
                ok = 1'b1;
            end else if (busy && !addr_valid) begin
                next_filter = 1'b1;
                nf++;
            end
        end
        if (!ok) chk("pass_timeout", 0, 1);
        @(negedge clk);
        chk("done_one_cycle{done,busy}", {done, busy}, 2'b00);
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic run_pass(input vec_t v);
        for (int f = 0; f < int'(v.num); f++)
            for (int e = 0; e < int'(v.size); e++)
                push_elem(v.base, v.size, v.inter, f, e);
        addr_ready = 1'b1;
        start_pass(v.base, v.size, v.num, v.inter);
        chk("start_latency{valid,busy,addr}", {addr_valid, busy, addr}, {2'b11, v.base});
        finish_pass(int'(v.num));
        chk("final{fstart,idx}", {filter_start_addr, filter_idx}, {v.exp_fstart, v.exp_idx});
    endtask

    initial begin
        vec_t rv;
        bit   found;

        vecs[0] = '{16'h0100, 4'd3,  8'd2, 1'b0, 16'h0103, 8'd1};
        vecs[1] = '{16'h0000, 4'd4,  8'd2, 1'b1, 16'h0008, 8'd1};
        vecs[2] = '{16'hFFFE, 4'd2,  8'd2, 1'b1, 16'h0002, 8'd1};
        vecs[3] = '{16'h1234, 4'd1,  8'd3, 1'b0, 16'h1236, 8'd2};
        vecs[4] = '{16'h8000, 4'd15, 8'd2, 1'b1, 16'h801E, 8'd1};

        rst = 1'b0; start = 1'b0; base_addr = '0; filter_size = '0; num_filters = '0;
        interleaved_mode = 1'b0; next_filter = 1'b0; addr_ready = 1'b0;
        #12;
        chk("reset_outputs", {addr, filter_start_addr, filter_idx, addr_valid, last_elem, busy, done}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {addr, filter_start_addr, filter_idx, addr_valid, last_elem, busy, done}, 0);

        for (int i = 0; i < 5; i++) run_pass(vecs[i]);

        // Backpressure on element 1, then skip on element 2 together with ready.
        for (int e = 0; e < 3; e++) push_elem(16'h0020, 4'd4, 1'b0, 0, e);
        for (int e = 0; e < 4; e++) push_elem(16'h0020, 4'd4, 1'b0, 1, e);
        addr_ready = 1'b1;
        start_pass(16'h0020, 4'd4, 8'd2, 1'b0);
        @(negedge clk);
        addr_ready = 1'b0;
        chk("stall0{valid,addr,last}", {addr_valid, addr, last_elem}, {1'b1, 16'h0021, 1'b0});
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            chk("stall_hold{valid,addr,last}", {addr_valid, addr, last_elem}, {1'b1, 16'h0021, 1'b0});
        end
        addr_ready = 1'b1;
        @(negedge clk);
        chk("elem2_addr", addr, 16'h0022);
        next_filter = 1'b1;
        @(negedge clk);
        next_filter = 1'b0;
        chk("skip{addr,idx,fstart}", {addr, filter_idx, filter_start_addr}, {16'h0024, 8'd1, 16'h0024});
        finish_pass(1);

        // Degenerate configuration: straight to DONE with no address.
        @(negedge clk);
        filter_size = 4'd3; num_filters = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("degenerate{busy,done,valid}", {busy, done, addr_valid}, 3'b110);
        @(negedge clk);
        chk("degenerate_idle{busy,done,valid}", {busy, done, addr_valid}, 3'b000);

        // A start while running is ignored.
        push_elem(16'h0300, 4'd2, 1'b0, 0, 0);
        push_elem(16'h0300, 4'd2, 1'b0, 0, 1);
        addr_ready = 1'b0;
        @(negedge clk);
        base_addr = 16'h0300; filter_size = 4'd2; num_filters = 8'd1; interleaved_mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        base_addr = 16'h0500; filter_size = 4'd5; num_filters = 8'd4;
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored{valid,busy,addr,fstart,idx}",
            {addr_valid, busy, addr, filter_start_addr, filter_idx},
            {2'b11, 16'h0300, 16'h0300, 8'd0});
        addr_ready = 1'b1;
        finish_pass(1);

        // Reset during filter 1, then restart from base.
        for (int e = 0; e < 3; e++) push_elem(16'h0040, 4'd3, 1'b0, 0, e);
        addr_ready = 1'b1;
        start_pass(16'h0040, 4'd3, 8'd2, 1'b0);
        found = 1'b0;
        for (int cyc = 0; cyc < 50 && !found; cyc++) begin
            if (busy && !addr_valid) found = 1'b1;
            else @(negedge clk);
        end
        chk("reach_wait", found, 1'b1);
        next_filter = 1'b1;
        @(negedge clk);
        next_filter = 1'b0;
        addr_ready = 1'b0;
        chk("filter1_run{valid,idx,addr}", {addr_valid, filter_idx, addr}, {1'b1, 8'd1, 16'h0043});
        chk("sb_empty_before_reset", sb.size(), 0);
        rst = 1'b0;
        #2;
        chk("reset_midpass_outputs",
            {addr, filter_start_addr, filter_idx, addr_valid, last_elem, busy, done}, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("no_done_in_reset", {done, busy}, 2'b00);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("idle_after_midpass_reset", {busy, done, addr_valid}, 3'b000);
        rv = '{16'h0040, 4'd3, 8'd2, 1'b0, 16'h0043, 8'd1};
        run_pass(rv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
